// File: rtl/decode_execute_reg.sv
// ID/EX pipeline register: decode control word, operands, PCs and register indices to execute; 1-cycle latency.
// StallE holds every E output, FlushE (over StallE) inserts a bubble; optional PIPE_BUBBLE_COUNT_EN adds BubbleCountE.
module decode_execute_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      StallE,
    input  logic                      FlushE,
    input  logic                      ValidD,
    input  logic                      RegWriteD,
    input  logic [3:0]                ALUControlD,
    input  logic                      ALUSrcAD,
    input  logic                      ALUSrcBD,
    input  logic                      MemWriteD,
    input  logic [1:0]                ResultSrcD,
    input  logic [1:0]                PCSrcD,
    input  logic [2:0]                AddressingControlD,
    input  logic [DATA_WIDTH-1:0]     RD1D,
    input  logic [DATA_WIDTH-1:0]     RD2D,
    input  logic [DATA_WIDTH-1:0]     PCD,
    input  logic [DATA_WIDTH-1:0]     PCPlus4D,
    input  logic [DATA_WIDTH-1:0]     ImmExtD,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] RdD,
    output logic                      ValidE,
    output logic                      RegWriteE,
    output logic [3:0]                ALUControlE,
    output logic                      ALUSrcAE,
    output logic                      ALUSrcBE,
    output logic                      MemWriteE,
    output logic [1:0]                ResultSrcE,
    output logic [1:0]                PCSrcE,
    output logic [2:0]                AddressingControlE,
    output logic [DATA_WIDTH-1:0]     RD1E,
    output logic [DATA_WIDTH-1:0]     RD2E,
    output logic [DATA_WIDTH-1:0]     PCE,
    output logic [DATA_WIDTH-1:0]     PCPlus4E,
    output logic [DATA_WIDTH-1:0]     ImmExtE,
    output logic [REG_ADDR_WIDTH-1:0] Rs1E,
    output logic [REG_ADDR_WIDTH-1:0] Rs2E,
    output logic [REG_ADDR_WIDTH-1:0] RdE
`ifdef PIPE_BUBBLE_COUNT_EN
    ,
    output logic [31:0]               BubbleCountE
`endif
);

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic [3:0] aluctrl;
        logic       srca;
        logic       srcb;
        logic       memwrite;
        logic [1:0] resultsrc;
        logic [1:0] pcsrc;
        logic [2:0] addrctl;
    } ctrl_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     rd1;
        logic [DATA_WIDTH-1:0]     rd2;
        logic [DATA_WIDTH-1:0]     pc;
        logic [DATA_WIDTH-1:0]     pcplus4;
        logic [DATA_WIDTH-1:0]     immext;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } data_t;

    ctrl_t ctrl_d, ctrl_q;
    data_t data_d, data_q;

    always_comb begin
        ctrl_d = '{valid: ValidD, regwrite: RegWriteD, aluctrl: ALUControlD,
                   srca: ALUSrcAD, srcb: ALUSrcBD, memwrite: MemWriteD,
                   resultsrc: ResultSrcD, pcsrc: PCSrcD, addrctl: AddressingControlD};
        // An empty decode slot must not carry side effects into execute.
        if (!ValidD) begin
            ctrl_d = '0;
        end
        data_d = '{rd1: RD1D, rd2: RD2D, pc: PCD, pcplus4: PCPlus4D, immext: ImmExtD,
                   rs1: Rs1D, rs2: Rs2D, rd: RdD};
    end

    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else if (!StallE) begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign ValidE             = ctrl_q.valid;
    assign RegWriteE          = ctrl_q.regwrite;
    assign ALUControlE        = ctrl_q.aluctrl;
    assign ALUSrcAE           = ctrl_q.srca;
    assign ALUSrcBE           = ctrl_q.srcb;
    assign MemWriteE          = ctrl_q.memwrite;
    assign ResultSrcE         = ctrl_q.resultsrc;
    assign PCSrcE             = ctrl_q.pcsrc;
    assign AddressingControlE = ctrl_q.addrctl;
    assign RD1E               = data_q.rd1;
    assign RD2E               = data_q.rd2;
    assign PCE                = data_q.pc;
    assign PCPlus4E           = data_q.pcplus4;
    assign ImmExtE            = data_q.immext;
    assign Rs1E               = data_q.rs1;
    assign Rs2E               = data_q.rs2;
    assign RdE                = data_q.rd;

`ifdef PIPE_BUBBLE_COUNT_EN
    logic [31:0] bubble_cnt;

    // Counts every edge that leaves a bubble in E; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (FlushE || (!StallE && !ValidD)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

    assign BubbleCountE = bubble_cnt;
`endif

endmodule
